// File: rtl/dm_ctrl.sv
// Data-memory controller: owns the DEPTH x DW data RAM, clears it after reset,
// performs single-cycle stores and registered loads, and flags out-of-range addresses.
module dm_ctrl #(
    parameter int          AW             = 8,
    parameter int          DW             = 8,
    parameter int          DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [2:0]  kLDM           = 3'b010,
    parameter logic [2:0]  kSTR           = 3'b011
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] dm_adr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          err_adr
);

    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_WORD = DEPTH_W - 1'b1;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          memWe;
    logic [IW-1:0] memIdx;
    logic [DW-1:0] memWdata;

    logic          adrInRange;
    logic [IW-1:0] reqIdx;

    assign adrInRange = ({1'b0, dm_adr} < DEPTH_W);
    assign reqIdx     = dm_adr[IW-1:0];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // RAM has no reset; the CLEAR sequence is what zeroes it.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem_q[memIdx] <= memWdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        memWe     = 1'b0;
        memIdx    = reqIdx;
        memWdata  = wr_data;

        case (state_q)
            CLEAR: begin
                memWe     = 1'b1;
                memIdx    = clr_cnt_q[IW-1:0];
                memWdata  = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if (op == kSTR) begin
                        if (adrInRange) begin
                            memWe = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (op == kLDM) begin
                        // Out-of-range loads still complete, returning zero.
                        rd_data_d = adrInRange ? mem_q[reqIdx] : '0;
                        if (!adrInRange) begin
                            err_d = 1'b1;
                        end
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_valid  = (state_q == READ);
    assign rd_data   = rd_data_q;
    assign err_adr   = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Randomized self-checking bench for dm_ctrl: a DEPTH=256 and a DEPTH=128 instance
// are driven against an array-based reference memory per instance.
module tb_dm_ctrl;

    localparam logic [2:0] LDM_OP = 3'b010;
    localparam logic [2:0] STR_OP = 3'b011;

    logic       clk;
    logic       rst       [2];
    logic       reqValid  [2];
    logic       reqReady  [2];
    logic [2:0] opIn      [2];
    logic [7:0] adrIn     [2];
    logic [7:0] dataIn    [2];
    logic [7:0] rdData    [2];
    logic       rdValid   [2];
    logic       busyOut   [2];
    logic       errAdr    [2];

    int         checks = 0;
    int         errors = 0;

    int         depth     [2] = '{256, 128};
    logic [7:0] modelMem  [2][256];
    logic       modelErr  [2];
    logic [7:0] modelRd   [2];

    dm_ctrl #(.AW(8), .DW(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1), .kLDM(LDM_OP), .kSTR(STR_OP)) dutA (
        .CLK(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .op(opIn[0]), .dm_adr(adrIn[0]), .wr_data(dataIn[0]), .rd_data(rdData[0]),
        .rd_valid(rdValid[0]), .busy(busyOut[0]), .err_adr(errAdr[0])
    );

    dm_ctrl #(.AW(8), .DW(8), .DEPTH(128), .CLEAR_ON_RESET(1'b1), .kLDM(LDM_OP), .kSTR(STR_OP)) dutB (
        .CLK(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .op(opIn[1]), .dm_adr(adrIn[1]), .wr_data(dataIn[1]), .rd_data(rdData[1]),
        .rd_valid(rdValid[1]), .busy(busyOut[1]), .err_adr(errAdr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset(input int sel);
        for (int i = 0; i < 256; i++) modelMem[sel][i] = 8'h00;
        modelErr[sel] = 1'b0;
        modelRd[sel]  = 8'h00;
    endtask

    // Counts edges from the current sample point until the instance leaves CLEAR.
    task automatic waitClear(input int sel);
        int cycles = 0;
        checkOutput("clearBusy", busyOut[sel], 1);
        checkOutput("clearReady", reqReady[sel], 0);
        // A store attempt held during CLEAR must never be accepted.
        reqValid[sel] = 1'b1;
        opIn[sel]     = STR_OP;
        adrIn[sel]    = 8'h05;
        dataIn[sel]   = 8'hFF;
        while (busyOut[sel] && cycles < 2000) begin
            tick();
            cycles++;
            if (busyOut[sel] && reqReady[sel]) checkOutput("clearReadyLeak", reqReady[sel], 0);
        end
        reqValid[sel] = 1'b0;
        checkOutput("clearLength", cycles, depth[sel]);
        checkOutput("idleReady", reqReady[sel], 1);
    endtask

    task automatic resetInst(input int sel);
        rst[sel] = 1'b1;
        #1;
        checkOutput("rstRdValid", rdValid[sel], 0);
        checkOutput("rstRdData", rdData[sel], 0);
        checkOutput("rstErr", errAdr[sel], 0);
        #1;
        rst[sel] = 1'b0;
        modelReset(sel);
    endtask

    task automatic applyStimulus(input int sel, input logic [2:0] o, input logic [7:0] a,
                                 input logic [7:0] d);
        int  waitCnt = 0;
        bit  inRange;
        while (!reqReady[sel] && waitCnt < 10) begin
            tick();
            waitCnt++;
        end
        if (!reqReady[sel]) checkOutput("readyTimeout", reqReady[sel], 1);
        reqValid[sel] = 1'b1;
        opIn[sel]     = o;
        adrIn[sel]    = a;
        dataIn[sel]   = d;
        tick();
        reqValid[sel] = 1'b0;
        inRange = (int'(a) < depth[sel]);
        if (o == STR_OP) begin
            if (inRange) modelMem[sel][a] = d;
            else         modelErr[sel] = 1'b1;
        end else if (o == LDM_OP) begin
            modelRd[sel] = inRange ? modelMem[sel][a] : 8'h00;
            if (!inRange) modelErr[sel] = 1'b1;
        end
        checkOutput("errAdr", errAdr[sel], modelErr[sel]);
        if (o == LDM_OP) begin
            checkOutput("loadValid", rdValid[sel], 1);
            checkOutput("loadData", rdData[sel], modelRd[sel]);
            checkOutput("readReady", reqReady[sel], 0);
            tick();
            checkOutput("pulseEnd", rdValid[sel], 0);
            checkOutput("dataHold", rdData[sel], modelRd[sel]);
        end else begin
            checkOutput("noValid", rdValid[sel], 0);
            checkOutput("stayIdle", reqReady[sel], 1);
            checkOutput("dataHold", rdData[sel], modelRd[sel]);
        end
    endtask

    initial begin
        logic [2:0] o;
        logic [7:0] a;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; reqValid[s] = 1'b0; opIn[s] = 3'b000;
            adrIn[s] = 8'h00; dataIn[s] = 8'h00;
        end
        #1;

        // Power-up clear on both instances, then directed loads of cleared words.
        resetInst(0);
        waitClear(0);
        resetInst(1);
        waitClear(1);
        applyStimulus(0, LDM_OP, 8'h07, 8'h00);
        applyStimulus(0, LDM_OP, 8'h05, 8'h00);

        // Store followed by load of the same word on the next cycle.
        applyStimulus(0, STR_OP, 8'h03, 8'hA5);
        applyStimulus(0, LDM_OP, 8'h03, 8'h00);

        // Back-to-back loads with req_valid held through READ.
        applyStimulus(0, STR_OP, 8'h04, 8'h3C);
        reqValid[0] = 1'b1; opIn[0] = LDM_OP; adrIn[0] = 8'h03;
        tick();
        checkOutput("b2bFirstValid", rdValid[0], 1);
        checkOutput("b2bFirstData", rdData[0], 8'hA5);
        checkOutput("b2bReadyLow", reqReady[0], 0);
        adrIn[0] = 8'h04;
        tick();
        checkOutput("b2bGap", rdValid[0], 0);
        checkOutput("b2bGapReady", reqReady[0], 1);
        tick();
        reqValid[0] = 1'b0;
        checkOutput("b2bSecondValid", rdValid[0], 1);
        checkOutput("b2bSecondData", rdData[0], 8'h3C);
        tick();
        modelRd[0] = 8'h3C;

        // Unrecognised opcode has no effect.
        applyStimulus(0, 3'b000, 8'hFF, 8'h5A);
        applyStimulus(0, LDM_OP, 8'hFF, 8'h00);

        // Out-of-range accesses on the 128-word instance.
        applyStimulus(1, STR_OP, 8'd200, 8'h11);
        applyStimulus(1, LDM_OP, 8'd72, 8'h00);
        applyStimulus(1, LDM_OP, 8'd200, 8'h00);
        applyStimulus(1, STR_OP, 8'd10, 8'h77);
        applyStimulus(1, LDM_OP, 8'd10, 8'h00);

        // Randomized traffic against the reference memories.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 300; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      o = STR_OP;
                else if (r < 8) o = LDM_OP;
                else begin
                    o = 3'($urandom_range(0, 7));
                    if (o == LDM_OP || o == STR_OP) o = 3'b000;
                end
                a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                applyStimulus(s, o, a, 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        // Reset in the middle of CLEAR restarts the full sequence.
        resetInst(0);
        for (int i = 0; i < 100; i++) tick();
        checkOutput("midClearBusy", busyOut[0], 1);
        resetInst(0);
        waitClear(0);
        applyStimulus(0, LDM_OP, 8'h03, 8'h00);

        // Reset during READ kills the pulse immediately.
        applyStimulus(0, STR_OP, 8'h20, 8'hC3);
        reqValid[0] = 1'b1; opIn[0] = LDM_OP; adrIn[0] = 8'h20;
        tick();
        reqValid[0] = 1'b0;
        checkOutput("preRstValid", rdValid[0], 1);
        checkOutput("preRstData", rdData[0], 8'hC3);
        resetInst(0);
        checkOutput("postRstValid", rdValid[0], 0);
        waitClear(0);
        applyStimulus(0, LDM_OP, 8'h20, 8'h00);

        // Sticky error on instance B is cleared only by reset.
        checkOutput("stickyErr", errAdr[1], 1);
        resetInst(1);
        waitClear(1);
        checkOutput("errCleared", errAdr[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
